// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared encodings, defaults and helpers for the button conditioner
package button_conditioner_pkg;

    // Default parameter values for the panel build
    localparam int DEF_CHANNELS        = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 8;
    localparam int DEF_LONG_CYCLES     = 64;
    localparam int DEF_REPEAT_CYCLES   = 16;

    // Hold FSM encodings, kept as plain constants so older code can share them
    localparam logic [1:0] ST_RELEASED = 2'd0;
    localparam logic [1:0] ST_HELD     = 2'd1;
    localparam logic [1:0] ST_LONG     = 2'd2;

    // Bits needed to hold 0..max_val; never narrower than one bit
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one button channel: synchroniser, debounce and hold FSM
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic tick_i,
    input  logic in_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o,
    output logic repeat_o
);

    // Debounce counter terminal is DEBOUNCE_CYCLES-1; hold counter must reach
    // whichever of the long and repeat terminals is larger.
    localparam int DB_W     = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HW       = cnt_width(HOLD_MAX);

    localparam logic [DB_W-1:0] DB_TERM   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]   LONG_TERM = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0]   RPT_TERM  = HW'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
    localparam bit              RPT_EN    = (REPEAT_CYCLES > 0);

    logic            s1_q, s2_q;
    logic            level_q, level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]      state_q, state_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            long_q, long_d;
    logic            rpt_q, rpt_d;
    logic            rise, fall;

    // Two-flop synchroniser, runs every clock independent of tick
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= in_raw_i;
            s2_q <= s1_q;
        end
    end

    // Debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing ticks
    always_comb begin
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        if (s2_q == level_q) begin
            db_cnt_d = '0;
        end else if (tick_i) begin
            if (db_cnt_q == DB_TERM) begin
                level_d  = ~level_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // Hold FSM: edges of the debounced level win over any counter terminal
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = rise;
        release_d  = fall;
        long_d     = 1'b0;
        rpt_d      = 1'b0;
        if (rise) begin
            state_d    = ST_HELD;
            hold_cnt_d = '0;
        end else if (fall) begin
            state_d    = ST_RELEASED;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                ST_RELEASED: begin
                    hold_cnt_d = '0;
                end
                ST_HELD: begin
                    if (tick_i) begin
                        if (hold_cnt_q == LONG_TERM) begin
                            long_d     = 1'b1;
                            hold_cnt_d = '0;
                            state_d    = ST_LONG;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                end
                ST_LONG: begin
                    // With repeat disabled the channel parks here until release
                    if (RPT_EN && tick_i) begin
                        if (hold_cnt_q == RPT_TERM) begin
                            rpt_d      = 1'b1;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d    = ST_RELEASED;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    // State, counters and registered event pulses
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            level_q    <= 1'b0;
            db_cnt_q   <= '0;
            state_q    <= ST_RELEASED;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            rpt_q      <= 1'b0;
        end else begin
            level_q    <= level_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            rpt_q      <= rpt_d;
        end
    end

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;
    assign repeat_o     = rpt_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - multi-channel button conditioner top level
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                tick_i,
    input  logic [CHANNELS-1:0] in_raw_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o,
    output logic [CHANNELS-1:0] long_press_o,
    output logic [CHANNELS-1:0] repeat_o
);

    // Channels share nothing but clock, reset and tick
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .tick_i       (tick_i),
            .in_raw_i     (in_raw_i[g]),
            .level_o      (level_o[g]),
            .press_o      (press_o[g]),
            .release_o    (release_o[g]),
            .long_press_o (long_press_o[g]),
            .repeat_o     (repeat_o[g])
        );
    end

endmodule
